ram_arb: RTL and testbench

RAM_ARB -- requirements
Module: ram_arb

---
 rtl/ram_arb_pkg.sv | 15 +
 rtl/ram_arb.sv | 128 ++++++++++++
 tb/tb_ram_arb.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// Shared definitions for the CPU/DMA RAM arbiter: FSM state encoding,
// port identifiers and the wait-counter width.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;
  localparam int   CNT_W    = 4;

endpackage

// File: rtl/ram_arb.sv
// Two-port (CPU/DMA) arbiter in front of a single-ported RAM with WAIT_CYCLES wait states.
// Optional macro RAM_ARB_RR_EN: simultaneous requests alternate by last grant instead of fixed DMA priority.
module ram_arb
  import ram_arb_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = 22
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [15:0]       cpu_data_in,
  input  logic              cpu_byte_op,
  output logic [15:0]       cpu_data_out,
  output logic              cpu_ack,
  input  logic              dma_rd,
  input  logic              dma_wr,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [15:0]       dma_data_in,
  input  logic              dma_byte_op,
  output logic [15:0]       dma_data_out,
  output logic              dma_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_data_out,
  output logic              ram_rd,
  output logic              ram_wr,
  output logic              ram_byte_op,
  input  logic [15:0]       ram_data_in,
  output state_t            dbg_state
);

  // Handshake: rd/wr are levels held by the requester until its ack; ack is a
  // one-cycle pulse in DONE on the served port only; rd+wr together means write.

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             mask_vld, mask_port;
  logic             grant, acc_wr;
  logic             cpu_elig, dma_elig, win_port, win_wr, last_cycle;
`ifdef RAM_ARB_RR_EN
  logic             last_grant;
`endif

  always_comb begin
    cpu_elig   = (cpu_rd | cpu_wr) && !(mask_vld && mask_port == PORT_CPU);
    dma_elig   = (dma_rd | dma_wr) && !(mask_vld && mask_port == PORT_DMA);
`ifdef RAM_ARB_RR_EN
    if (cpu_elig && dma_elig) win_port = ~last_grant;
    else                      win_port = dma_elig ? PORT_DMA : PORT_CPU;
`else
    win_port   = dma_elig ? PORT_DMA : PORT_CPU;
`endif
    win_wr     = (win_port == PORT_DMA) ? dma_wr : cpu_wr;
    last_cycle = (cnt == CNT_W'(WAIT_CYCLES - 1));
    state_next = state;
    case (state)
      IDLE:    if (cpu_elig || dma_elig) state_next = ACCESS;
      ACCESS:  if (last_cycle) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt          <= '0;
      mask_vld     <= 1'b0;
      mask_port    <= PORT_CPU;
      grant        <= PORT_CPU;
      acc_wr       <= 1'b0;
      ram_addr     <= '0;
      ram_data_out <= '0;
      ram_byte_op  <= 1'b0;
      cpu_data_out <= '0;
      dma_data_out <= '0;
    end else begin
      // The served port sits out exactly the first IDLE cycle after its ack.
      mask_vld <= (state == DONE);
      case (state)
        IDLE: begin
          if (cpu_elig || dma_elig) begin
            cnt          <= '0;
            grant        <= win_port;
            acc_wr       <= win_wr;
            ram_addr     <= (win_port == PORT_DMA) ? dma_addr    : cpu_addr;
            ram_data_out <= (win_port == PORT_DMA) ? dma_data_in : cpu_data_in;
            ram_byte_op  <= (win_port == PORT_DMA) ? dma_byte_op : cpu_byte_op;
          end
        end
        ACCESS: begin
          if (last_cycle) begin
            cnt <= '0;
            if (!acc_wr) begin
              if (grant == PORT_DMA) dma_data_out <= ram_data_in;
              else                   cpu_data_out <= ram_data_in;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE:    mask_port <= grant;
        default: ;
      endcase
    end
  end

`ifdef RAM_ARB_RR_EN
  // Reset to CPU so the first contested grant goes to DMA.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                      last_grant <= PORT_CPU;
    else if (state == IDLE && (cpu_elig || dma_elig)) last_grant <= win_port;
  end
`endif

  assign ram_rd    = (state == ACCESS) && !acc_wr;
  assign ram_wr    = (state == ACCESS) &&  acc_wr;
  assign cpu_ack   = (state == DONE) && (grant == PORT_CPU);
  assign dma_ack   = (state == DONE) && (grant == PORT_DMA);
  assign dbg_state = state;

endmodule

// File: tb/tb_ram_arb.sv
// Bench for ram_arb: transaction-level timing model checked every cycle, plus directed literal cases.
// Build with RAM_ARB_RR_EN to exercise the round-robin variant (WAIT_CYCLES=3 there).
module tb_ram_arb;
  import ram_arb_pkg::*;

`ifdef RAM_ARB_RR_EN
  localparam int W = 3;
`else
  localparam int W = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_rd, cpu_wr, cpu_byte_op, dma_rd, dma_wr, dma_byte_op;
  logic [21:0] cpu_addr, dma_addr, ram_addr;
  logic [15:0] cpu_data_in, dma_data_in, cpu_data_out, dma_data_out;
  logic [15:0] ram_data_out, ram_data_in;
  logic        cpu_ack, dma_ack, ram_rd, ram_wr, ram_byte_op;
  state_t      dbg_state;

  logic [15:0] ram_mem [0:1023];
  logic [15:0] mem_exp [0:1023];
  int cyc = 0;
  int n_total = 0;
  int n_bad = 0;
  int cpu_acks = 0;
  int dma_acks = 0;

  ram_arb #(.WAIT_CYCLES(W), .ADDR_W(22)) dut (
    .clk(clk), .reset(reset),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in),
    .cpu_byte_op(cpu_byte_op), .cpu_data_out(cpu_data_out), .cpu_ack(cpu_ack),
    .dma_rd(dma_rd), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_data_in(dma_data_in),
    .dma_byte_op(dma_byte_op), .dma_data_out(dma_data_out), .dma_ack(dma_ack),
    .ram_addr(ram_addr), .ram_data_out(ram_data_out), .ram_rd(ram_rd), .ram_wr(ram_wr),
    .ram_byte_op(ram_byte_op), .ram_data_in(ram_data_in), .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  function automatic logic [15:0] init_word(input int i);
    if (i == 512) return 16'o12345;
    return 16'(i * 40503) ^ 16'h5a5a;
  endfunction

  // RAM byte-lane rule: a byte write replaces the low byte only.
  function automatic logic [15:0] lane_write(input logic [15:0] old, input logic [15:0] d, input logic bop);
    return bop ? {old[15:8], d[7:0]} : d;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- RAM behaviour ----------------
  assign ram_data_in = ram_mem[ram_addr[9:0]];

  initial begin
    for (int i = 0; i < 1024; i++) ram_mem[i] = init_word(i);
    forever begin
      @(negedge clk);
      if (ram_wr) ram_mem[ram_addr[9:0]] = lane_write(ram_mem[ram_addr[9:0]], ram_data_out, ram_byte_op);
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  // A grant decided in cycle g puts the RAM strobe in g+1..g+W, ack in g+W+1,
  // and arbitration resumes at g+W+2 with the just-served port excluded there.
  initial begin
    bit          have_g;
    int          g_cyc, k, masked;
    bit          in_acc, in_done, creq, dreq;
    logic        m_win, m_wr, m_bop, last_srv;
    logic [21:0] m_addr;
    logic [15:0] m_data;
    logic [15:0] m_dout [2];
    have_g = 0; g_cyc = 0; m_win = 0; m_wr = 0; m_bop = 0; last_srv = 0;
    m_addr = 0; m_data = 0; m_dout[0] = 0; m_dout[1] = 0;
    for (int i = 0; i < 1024; i++) mem_exp[i] = init_word(i);
    forever begin
      @(negedge clk);
      if (!reset) begin
        have_g = 0; m_win = 0; m_wr = 0; m_bop = 0; m_addr = 0; m_data = 0;
        m_dout[0] = 0; m_dout[1] = 0; last_srv = 0;
      end
      k       = have_g ? cyc - g_cyc : 0;
      in_acc  = have_g && k >= 1 && k <= W;
      in_done = have_g && k == W + 1;
      check("ram_rd",       ram_rd,       in_acc && !m_wr);
      check("ram_wr",       ram_wr,       in_acc && m_wr);
      check("cpu_ack",      cpu_ack,      in_done && m_win == 1'b0);
      check("dma_ack",      dma_ack,      in_done && m_win == 1'b1);
      check("ram_addr",     ram_addr,     m_addr);
      check("ram_data_out", ram_data_out, m_data);
      check("ram_byte_op",  ram_byte_op,  m_bop);
      check("cpu_data_out", cpu_data_out, m_dout[0]);
      check("dma_data_out", dma_data_out, m_dout[1]);
      if (cpu_ack) cpu_acks++;
      if (dma_ack) dma_acks++;
      if (reset) begin
        if (in_acc && k == W && !m_wr) m_dout[m_win] = mem_exp[m_addr[9:0]];
        if (!have_g || k >= W + 2) begin
          masked = (have_g && k == W + 2) ? int'(m_win) : 2;
          creq = (cpu_rd | cpu_wr) && masked != 0;
          dreq = (dma_rd | dma_wr) && masked != 1;
          if (creq || dreq) begin
`ifdef RAM_ARB_RR_EN
            if (creq && dreq) m_win = ~last_srv;
            else              m_win = dreq;
`else
            m_win = dreq;
`endif
            have_g   = 1;
            g_cyc    = cyc;
            last_srv = m_win;
            m_wr     = m_win ? dma_wr      : cpu_wr;
            m_addr   = m_win ? dma_addr    : cpu_addr;
            m_data   = m_win ? dma_data_in : cpu_data_in;
            m_bop    = m_win ? dma_byte_op : cpu_byte_op;
            if (m_wr) mem_exp[m_addr[9:0]] = lane_write(mem_exp[m_addr[9:0]], m_data, m_bop);
          end else begin
            have_g = 0;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_all();
    cpu_rd = 0; cpu_wr = 0; dma_rd = 0; dma_wr = 0;
    cpu_byte_op = 0; dma_byte_op = 0;
  endtask

  task automatic do_reset(input int n);
    reset = 0;
    drop_all();
    repeat (n) next_cycle();
    reset = 1;
    next_cycle();
  endtask

  // Waits (bounded) for an ack on one port; lat counts the request cycle as 1.
  task automatic wait_ack(input bit is_dma, input int t0, output int lat, output int acc_n,
                          output logic [21:0] acc_a, output logic acc_b);
    lat = -1; acc_n = 0; acc_a = 0; acc_b = 0;
    for (int i = 0; i < 60 && lat < 0; i++) begin
      @(negedge clk);
      if (ram_rd | ram_wr) begin
        acc_n++; acc_a = ram_addr; acc_b = ram_byte_op;
      end
      if (is_dma ? dma_ack : cpu_ack) lat = cyc - t0 + 1;
    end
  endtask

  task automatic agent_step(input int acks, inout int seen, inout logic rd, inout logic wr,
                            inout logic [21:0] addr, inout logic [15:0] data, inout logic bop);
    int op;
    if (acks != seen) begin
      seen = acks; rd = 0; wr = 0;
    end else if ((rd | wr) && $urandom_range(0, 15) == 0) begin
      rd = 0; wr = 0;
    end else if (!(rd | wr) && $urandom_range(0, 2) == 0) begin
      op   = $urandom_range(0, 3);
      rd   = (op == 0 || op == 2 || op == 3);
      wr   = (op == 1 || op == 2);
      addr = 22'($urandom);
      data = 16'($urandom);
      bop  = 1'($urandom_range(0, 1));
    end
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int          t0, lat, lat2, acc_n, n_ack, first, errs, cpu_seen, dma_seen;
    logic [21:0] acc_a;
    logic        acc_b, seen;
    logic [15:0] w;
    int          who [4];
    int          when_c [4];

    reset = 0;
    drop_all();
    cpu_addr = 0; dma_addr = 0; cpu_data_in = 0; dma_data_in = 0;
    repeat (2) next_cycle();
    check("rst_ram_rd", ram_rd, 0);
    check("rst_ram_wr", ram_wr, 0);
    check("rst_acks", {cpu_ack, dma_ack}, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_state", dbg_state, 0);
    reset = 1;
    repeat (2) next_cycle();

    // single CPU read
    t0 = cyc; cpu_rd = 1; cpu_addr = 22'o1000;
    wait_ack(0, t0, lat, acc_n, acc_a, acc_b);
    next_cycle(); cpu_rd = 0;
    check("rd_lat", lat, W + 2);
    check("rd_strobe_cycles", acc_n, W);
    check("rd_data", cpu_data_out, 16'o12345);

    // simultaneous writes: DMA first, CPU in the masked IDLE cycle after
    repeat (2) next_cycle();
    t0 = cyc;
    cpu_wr = 1; cpu_addr = 22'd200; cpu_data_in = 16'hc0c0;
    dma_wr = 1; dma_addr = 22'd100; dma_data_in = 16'hd0d0;
    wait_ack(1, t0, lat, acc_n, acc_a, acc_b);
    next_cycle(); dma_wr = 0;
    wait_ack(0, t0, lat2, acc_n, acc_a, acc_b);
    next_cycle(); cpu_wr = 0;
    check("sim_dma_lat", lat, W + 2);
    check("sim_cpu_lat", lat2, 2 * W + 4);
    repeat (2) next_cycle();
    check("sim_mem_dma", ram_mem[100], 16'hd0d0);
    check("sim_mem_cpu", ram_mem[200], 16'hc0c0);

    // byte write
    t0 = cyc; cpu_wr = 1; cpu_byte_op = 1; cpu_addr = 22'o1001; cpu_data_in = 16'o177;
    wait_ack(0, t0, lat, acc_n, acc_a, acc_b);
    next_cycle(); cpu_wr = 0; cpu_byte_op = 0;
    check("byte_lat", lat, W + 2);
    check("byte_op_out", acc_b, 1);
    check("byte_addr", acc_a, 22'o1001);
    repeat (2) next_cycle();
    w = init_word(513);
    check("byte_mem", ram_mem[513], {w[15:8], 8'o177});

    // DMA streaming with a pending CPU read
    repeat (2) next_cycle();
    t0 = cyc; dma_rd = 1; dma_addr = 22'o1000; cpu_rd = 1; cpu_addr = 22'o3000;
    wait_ack(0, t0, lat, acc_n, acc_a, acc_b);
    next_cycle(); cpu_rd = 0;
    check("stream_cpu_lat", lat, 2 * W + 4);
    repeat (3) next_cycle();
    t0 = cyc; cpu_rd = 1;
    wait_ack(0, t0, lat, acc_n, acc_a, acc_b);
    next_cycle(); cpu_rd = 0; dma_rd = 0;
    check("stream_cpu2_bound", (lat >= W + 2 && lat <= 2 * W + 4), 1);

    // reset in the middle of an access
    repeat (W + 4) next_cycle();
    t0 = cyc; cpu_rd = 1; cpu_addr = 22'o1000; seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (ram_rd) seen = 1;
    end
    check("abort_reached_access", seen, 1);
    #1 reset = 0; cpu_rd = 0;
    #1;
    check("abort_rd_drop", ram_rd, 0);
    check("abort_wr_drop", ram_wr, 0);
    check("abort_dout_clr", cpu_data_out, 0);
    n_ack = 0;
    repeat (4) begin
      @(negedge clk);
      if (cpu_ack | dma_ack) n_ack++;
    end
    check("abort_no_ack", n_ack, 0);
    next_cycle(); reset = 1; next_cycle();
    t0 = cyc; cpu_rd = 1;
    wait_ack(0, t0, lat, acc_n, acc_a, acc_b);
    next_cycle(); cpu_rd = 0;
    check("post_abort_lat", lat, W + 2);
    check("post_abort_data", cpu_data_out, 16'o12345);

    // fresh simultaneous request right after a DMA-only access
    repeat (2) next_cycle();
    t0 = cyc; dma_wr = 1; dma_addr = 22'd300; dma_data_in = 16'h1234;
    wait_ack(1, t0, lat, acc_n, acc_a, acc_b);
    next_cycle(); dma_wr = 0;
    repeat (2) next_cycle();
    cpu_rd = 1; cpu_addr = 22'd301; dma_rd = 1; dma_addr = 22'd302; first = -1;
    for (int i = 0; i < 40 && first < 0; i++) begin
      @(negedge clk);
      if (cpu_ack) first = 0;
      else if (dma_ack) first = 1;
    end
    next_cycle(); drop_all();
`ifdef RAM_ARB_RR_EN
    check("fresh_winner", first, 0);
`else
    check("fresh_winner", first, 1);
`endif

    // both ports requesting continuously from reset
    repeat (W + 4) next_cycle();
    do_reset(2);
    for (int i = 0; i < 4; i++) begin who[i] = 2; when_c[i] = 0; end
    cpu_rd = 1; cpu_addr = 22'd10; dma_rd = 1; dma_addr = 22'd20; n_ack = 0;
    for (int i = 0; i < 100 && n_ack < 4; i++) begin
      @(negedge clk);
      if (cpu_ack || dma_ack) begin
        who[n_ack] = dma_ack ? 1 : 0; when_c[n_ack] = cyc; n_ack++;
      end
    end
    next_cycle(); drop_all();
    for (int i = 0; i < 4; i++) begin
      check("alt_who", who[i], (i % 2 == 0) ? 1 : 0);
      if (i > 0) check("alt_gap", when_c[i] - when_c[i-1], W + 2);
    end

    // random traffic from both requesters
    repeat (2 * W + 6) next_cycle();
    cpu_seen = cpu_acks; dma_seen = dma_acks;
    for (int c = 0; c < 3000; c++) begin
      next_cycle();
      agent_step(cpu_acks, cpu_seen, cpu_rd, cpu_wr, cpu_addr, cpu_data_in, cpu_byte_op);
      agent_step(dma_acks, dma_seen, dma_rd, dma_wr, dma_addr, dma_data_in, dma_byte_op);
    end
    drop_all();
    repeat (2 * W + 6) next_cycle();

    errs = 0;
    for (int i = 0; i < 1024; i++) if (ram_mem[i] !== mem_exp[i]) errs++;
    check("mem_final", errs, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
